// File: rtl/spawn_scheduler.sv
// Respawn scheduler: latches revive requests, waits SPAWN_DELAY cycles, then grants
// free spawn points round-robin across requesters; also raises sticky game-over/win flags.

module spawn_req_slot (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic set_i,
  input  logic clr_i,
  input  logic flush_i,
  output logic pend_o
);
  // set beats a same-cycle grant clear; flush (end of game) beats both
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    pend_o <= 1'b0;
    else if (flush_i) pend_o <= 1'b0;
    else if (set_i)   pend_o <= 1'b1;
    else if (clr_i)   pend_o <= 1'b0;
  end
endmodule

module spawn_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int NUM_PLAYER  = 2,
  parameter int NUM_SPAWN   = 2,
  parameter int SPAWN_DELAY = 1000000,
  parameter int SP_W        = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 enable_i,
  input  logic [NUM_REQ-1:0]   revive_req_i,
  input  logic [4*NUM_REQ-1:0] lives_left_i,
  input  logic [NUM_SPAWN-1:0] spawn_busy_i,
  input  logic                 eagle_hit_i,
  output logic [NUM_REQ-1:0]   spawn_grant_o,
  output logic [SP_W-1:0]      spawn_point_o,
  output logic [NUM_REQ-1:0]   pending_o,
  output logic                 game_over_o,
  output logic                 game_win_o
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;

  typedef enum logic [2:0] {IDLE, DELAY, ARB, GRANT, OVER} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] pending, lives_nz, req_set, win_oh;
  logic [PTR_W-1:0]   win_idx, rr_next;
  logic [SP_W-1:0]    free_pt;
  logic               win_found, pt_found;
  logic               players_dead, enemies_dead;
  logic               over_set, win_set, end_set, flush, grant_clr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      lives_nz[i] = (lives_left_i[4*i +: 4] != 4'd0);
  end

  assign req_set = revive_req_i & lives_nz;

  // Round-robin search starting at rr_ptr, wrapping around
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_oh    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && pending[idx]) begin
        win_found   = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = PTR_W'(idx);
      end
    end
  end

  assign rr_next = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    free_pt  = '0;
    pt_found = 1'b0;
    for (int j = 0; j < NUM_SPAWN; j++) begin
      if (!pt_found && !spawn_busy_i[j]) begin
        pt_found = 1'b1;
        free_pt  = SP_W'(j);
      end
    end
  end

  always_comb begin
    players_dead = 1'b1;
    enemies_dead = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lives_nz[i] || pending[i]) begin
        if (i < NUM_PLAYER) players_dead = 1'b0;
        else                enemies_dead = 1'b0;
      end
    end
  end

  // Once either flag is up the other can never follow
  assign over_set  = !game_over_o && !game_win_o && (eagle_hit_i || players_dead);
  assign win_set   = !game_over_o && !game_win_o && !over_set && enemies_dead;
  assign end_set   = over_set || win_set;
  assign flush     = (state_q == OVER) || end_set;
  assign grant_clr = (state_q == ARB) && enable_i && win_found && pt_found && !end_set;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    spawn_req_slot u_slot (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .set_i    (req_set[g]),
      .clr_i    (grant_clr && win_oh[g]),
      .flush_i  (flush),
      .pend_o   (pending[g])
    );
  end

  assign pending_o = pending;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      spawn_grant_o <= '0;
      spawn_point_o <= '0;
      game_over_o   <= 1'b0;
      game_win_o    <= 1'b0;
    end else begin
      spawn_grant_o <= '0;
      spawn_point_o <= '0;
      if (over_set) game_over_o <= 1'b1;
      if (win_set)  game_win_o  <= 1'b1;
      if (end_set) begin
        state_q <= OVER;
      end else if (enable_i) begin
        case (state_q)
          IDLE: if (|pending) begin
            state_q <= DELAY;
            cnt_q   <= '0;
          end
          DELAY: begin
            if (cnt_q == CNT_W'(SPAWN_DELAY-1)) state_q <= ARB;
            else                                cnt_q   <= cnt_q + CNT_W'(1);
          end
          ARB: begin
            if (!win_found) begin
              state_q <= IDLE;
            end else if (pt_found) begin
              state_q       <= GRANT;
              spawn_grant_o <= win_oh;
              spawn_point_o <= free_pt;
              rr_ptr_q      <= rr_next;
            end
          end
          GRANT: begin
            if (|pending) begin
              state_q <= DELAY;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
          OVER:    state_q <= OVER;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
